bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the generalised successor of the fixed 11-bit converter:
- input width and output digit count are parameters;
- valid/ready handshakes are on both sides, so output backpressure is supported;
- an overflow flag reports values that do not fit in the digit count;
- an optional signed mode is available.

It sits between binary datapaths and display/UART formatting logic.

## Interface
- `BIN_W`, default 11: binary input width, ≥ 2.
- `DIG`, default 4: number of BCD output digits, ≥ 1. The output is `4*DIG` bits.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bin` in `BIN_W`: binary operand, sampled on input handshake.
- `bin_vld` in 1: input valid.
- `bin_rdy` out 1: converter can accept an input.
- `bcd` out `4*DIG`: packed BCD result, digit 0 in bits [3:0].
- `bcd_neg` out 1: result sign (only when `BIN2BCD_SIGNED_EN` is defined).
- `bcd_ovf` out 1: value ≥ 10^DIG; `bcd` then holds value mod 10^DIG.
- `bcd_vld` out 1: result valid.
- `bcd_rdy` in 1: downstream accepts the result.

## Operation
- FSM states are IDLE, CONV and DONE.
- Reset puts the FSM in IDLE. Reset values: `bin_rdy`=1, `bcd_vld`=0, `bcd`=0, `bcd_neg`=0, `bcd_ovf`=0.
- IDLE:
  - `bin_rdy`=1.
  - On `bin_vld`&&`bin_rdy`:
    - latch the operand magnitude into the shift register;
    - clear the BCD register and the overflow flag;
    - load the bit counter with `BIN_W`;
    - go to CONV.
- CONV, once per cycle:
  - every 4-bit digit ≥5 gets +3;
  - then the {BCD, operand} register shifts left by 1;
  - the bit shifted out of the top digit is ORed into the overflow flag;
  - the counter decrements.
  - When the counter reaches 0 (after `BIN_W` shifts), go to DONE.
- DONE:
  - `bcd_vld`=1; `bcd`, `bcd_neg` and `bcd_ovf` are stable.
  - On `bcd_vld`&&`bcd_rdy`, go to IDLE.
- `bin_rdy` is 1 only in IDLE. Inputs are never accepted during CONV or DONE, and `bin`/`bin_vld` are ignored there.
- Outputs hold their last value after the output handshake until the next result is produced. Only `bcd_vld` drops.
- Arithmetic:
  - The result is exact decimal doubling per step, so `bcd` equals value mod 10^DIG.
  - `bcd_ovf`=1 iff value ≥ 10^DIG.
  - No width check is done at elaboration.
- `rst` asserted in any state, including mid-CONV, aborts the operation. The block returns to IDLE with reset output values on the next edge, and no partial result is flagged valid.

## Timing
- The input handshake occurs at edge E0.
- `bcd_vld` goes high after edge E0+`BIN_W`+1 (`BIN_W` conversion edges plus the CONV→DONE transition). With the default width that is 12 cycles after acceptance.
- The output handshake occurs at edge Ek. `bcd_vld`=0 and `bin_rdy`=1 from Ek onward, so the next acceptance is possible at Ek+1.
- Maximum throughput is one conversion per `BIN_W`+3 cycles.
- `bcd_rdy` may be high before `bcd_vld`. The handshake then completes on the first DONE cycle.
- `bin_vld` may be asserted continuously. Each acceptance uses the `bin` value present on that edge.

## Configuration
- Macro `BIN2BCD_SIGNED_EN`.
- Defined:
  - `bin` is two's complement.
  - At acceptance, the MSB is captured into `bcd_neg` and the absolute value is loaded.
  - −2^(BIN_W−1) converts to magnitude 2^(BIN_W−1) with no loss.
- Undefined:
  - `bin` is unsigned.
  - The `bcd_neg` port still exists and is tied to 0.

## Test plan
1. Defaults, unsigned: `bin`=0x020, `bcd_rdy`=1 → `bcd`=0x0032, `bcd_ovf`=0, with `bcd_vld` high exactly 12 cycles after acceptance.
2. Back-to-back inputs with `bin_vld` held high: 0x39C then 0x79C → `bcd`=0x0924 then 0x1948. The second input is accepted only after the first output handshake. 0x7FF → `bcd`=0x2047.
3. `DIG`=3, `bin`=0x7FF (2047) → `bcd`=0x047, `bcd_ovf`=1. `bin`=0x3E7 (999) → `bcd`=0x999, `bcd_ovf`=0.
4. Backpressure: hold `bcd_rdy`=0 for 5 cycles after `bcd_vld` rises → `bcd` and `bcd_vld` stable and `bin_rdy`=0 throughout. When `bcd_rdy` rises, the result is consumed in 1 cycle.
5. Reset mid-conversion: assert `rst` 4 cycles into CONV → next cycle `bin_rdy`=1, `bcd_vld`=0, `bcd`=0. A fresh conversion of 0x020 then yields 0x0032.
6. With `BIN2BCD_SIGNED_EN`:
   - 0x79C (−100) → `bcd`=0x0100, `bcd_neg`=1;
   - 0x400 (−1024) → `bcd`=0x1024, `bcd_neg`=1;
   - 0x020 → `bcd`=0x0032, `bcd_neg`=0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Takes BIN_W-bit binary operands over a valid/ready input handshake and returns
// DIG packed BCD digits over a valid/ready output handshake, with an overflow flag
// when the value does not fit in DIG digits.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's-complement input, sign on bcd_neg).
module bin2bcd_seq #(
  parameter int unsigned BIN_W = 11,
  parameter int unsigned DIG   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_W-1:0]     bin,
  input  logic                 bin_vld,
  output logic                 bin_rdy,
  output logic [4*DIG-1:0]     bcd,
  output logic                 bcd_neg,
  output logic                 bcd_ovf,
  output logic                 bcd_vld,
  input  logic                 bcd_rdy
);

  localparam int unsigned BCD_W = 4 * DIG;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   sh;        // operand bits still to be shifted in
  logic [BCD_W-1:0]   acc;       // working BCD accumulator
  logic [BCD_W-1:0]   acc_adj;   // accumulator after per-digit +3 correction
  logic               ovf_acc;   // sticky carry out of the top digit
  logic [CNT_W-1:0]   cnt;       // remaining shift steps
  logic [BIN_W-1:0]   mag;       // magnitude of the incoming operand
  logic               accept;

  assign accept = (state == IDLE) && bin_vld && bin_rdy;

`ifdef BIN2BCD_SIGNED_EN
  logic neg_in;
  logic neg_acc;

  // Two's-complement magnitude; the most negative value maps to 2^(BIN_W-1) unsigned.
  always_comb begin
    neg_in = bin[BIN_W-1];
    mag    = bin;
    if (neg_in) begin
      mag = BIN_W'(~bin + BIN_W'(1));
    end
  end

  // Sign is staged with the operand and published together with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_acc <= 1'b0;
      bcd_neg <= 1'b0;
    end else if (accept) begin
      neg_acc <= neg_in;
    end else if ((state == CONV) && (cnt == '0)) begin
      bcd_neg <= neg_acc;
    end
  end
`else
  // Unsigned operand: the magnitude is the input itself and there is no sign.
  always_comb begin
    mag = bin;
  end

  assign bcd_neg = 1'b0;
`endif

  // Add-3 correction on every digit that is 5 or more before the next doubling.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(DIG); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Control FSM with the shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_rdy <= 1'b1;
      bcd_vld <= 1'b0;
      bcd     <= '0;
      bcd_ovf <= 1'b0;
      sh      <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh      <= mag;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            bin_rdy <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          if (cnt == '0) begin
            // All bits consumed: publish the result; outputs stay put until the next one.
            bcd     <= acc;
            bcd_ovf <= ovf_acc;
            bcd_vld <= 1'b1;
            state   <= DONE;
          end else begin
            {acc, sh} <= {acc_adj[BCD_W-2:0], sh, 1'b0};
            ovf_acc   <= ovf_acc | acc_adj[BCD_W-1];
            cnt       <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (bcd_rdy) begin
            bcd_vld <= 1'b0;
            bin_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bin_rdy <= 1'b1;
          bcd_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: two instances (4 digits and 3 digits) share the stimulus;
// a transaction-level reference tracks acceptance, latency and expected results.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W = 11;
  localparam int          LAT   = BIN_W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] bin;
  logic        bin_vld;
  logic        bcd_rdy;

  logic        rdy0, vld0, neg0, ovf0;
  logic [15:0] bcd0;
  logic        rdy1, vld1, neg1, ovf1;
  logic [11:0] bcd1;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIG(4)) u_dut4 (
    .clk(clk), .rst(rst), .bin(bin), .bin_vld(bin_vld), .bin_rdy(rdy0),
    .bcd(bcd0), .bcd_neg(neg0), .bcd_ovf(ovf0), .bcd_vld(vld0), .bcd_rdy(bcd_rdy)
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIG(3)) u_dut3 (
    .clk(clk), .rst(rst), .bin(bin), .bin_vld(bin_vld), .bin_rdy(rdy1),
    .bcd(bcd1), .bcd_neg(neg1), .bcd_ovf(ovf1), .bcd_vld(vld1), .bcd_rdy(bcd_rdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: decimal value of the operand, reduced modulo 10^dig, written out as BCD.
  function automatic void model(input logic [10:0] b, input int dig,
                                output logic [15:0] r, output logic ovf, output logic neg);
    int unsigned mag;
    int unsigned pw;
    int unsigned v;
`ifdef BIN2BCD_SIGNED_EN
    neg = b[10];
    mag = neg ? (32'd2048 - 32'(b)) : 32'(b);
`else
    neg = 1'b0;
    mag = 32'(b);
`endif
    pw = 1;
    for (int i = 0; i < dig; i++) pw = pw * 10;
    ovf = (mag >= pw);
    v = mag % pw;
    r = '0;
    for (int i = 0; i < dig; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  // Transaction tracker: one operand in flight, result due LAT edges after acceptance.
  bit          armed   = 1'b0;
  bit          pending = 1'b0;
  int          since   = 0;
  int          n_results = 0;
  logic [10:0] cur;
  logic [15:0] h_bcd0, h_bcd1, tmp;
  logic        h_ovf0, h_ovf1, h_neg0, h_neg1;

  always @(posedge clk) begin
    if (rst) begin
      armed   = 1'b1;
      pending = 1'b0;
      since   = 0;
      h_bcd0  = '0; h_bcd1 = '0;
      h_ovf0  = 1'b0; h_ovf1 = 1'b0;
      h_neg0  = 1'b0; h_neg1 = 1'b0;
    end else if (armed) begin
      if (pending && since >= LAT) begin
        if (bcd_rdy) begin
          pending = 1'b0;
          n_results++;
        end
      end else if (pending) begin
        since++;
        if (since == LAT) begin
          model(cur, 4, h_bcd0, h_ovf0, h_neg0);
          model(cur, 3, tmp, h_ovf1, h_neg1);
          h_bcd1 = {4'h0, tmp[11:0]};
        end
      end else if (bin_vld) begin
        pending = 1'b1;
        since   = 0;
        cur     = bin;
      end
    end
  end

  // Per-cycle comparison of both instances against the tracker.
  always @(negedge clk) begin
    if (armed) begin
      logic exp_vld;
      logic exp_rdy;
      exp_vld = pending && (since >= LAT);
      exp_rdy = !pending;
      check("vld4", 16'(vld0), 16'(exp_vld));
      check("rdy4", 16'(rdy0), 16'(exp_rdy));
      check("bcd4", bcd0, h_bcd0);
      check("ovf4", 16'(ovf0), 16'(h_ovf0));
      check("neg4", 16'(neg0), 16'(h_neg0));
      check("vld3", 16'(vld1), 16'(exp_vld));
      check("rdy3", 16'(rdy1), 16'(exp_rdy));
      check("bcd3", {4'h0, bcd1}, h_bcd1);
      check("ovf3", 16'(ovf1), 16'(h_ovf1));
      check("neg3", 16'(neg1), 16'(h_neg1));
    end
  end

  // Offer an operand and return on the negedge after it was accepted.
  task automatic send(input logic [10:0] b, input bit keep);
    int n = 0;
    bin     = b;
    bin_vld = 1'b1;
    while (!rdy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) check("send_timeout", 16'(rdy0), 16'd1);
    @(negedge clk);
    if (!keep) bin_vld = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (!vld0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!vld0) check("vld_timeout", 16'(vld0), 16'd1);
  endtask

  logic [15:0] pr;
  logic        po, pn;
  logic [15:0] cap;
  int          lat;

  initial begin
    rst = 1'b1; bin = '0; bin_vld = 1'b0; bcd_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Model pins against hand-computed values.
    model(11'h020, 4, pr, po, pn); check("pin_020", pr, 16'h0032); check("pin_020_neg", 16'(pn), 16'd0);
    model(11'h39C, 4, pr, po, pn); check("pin_39C", pr, 16'h0924);
    model(11'h3E7, 3, pr, po, pn); check("pin_3E7", pr, 16'h0999); check("pin_3E7_ovf", 16'(po), 16'd0);
`ifdef BIN2BCD_SIGNED_EN
    model(11'h79C, 4, pr, po, pn); check("pin_79C", pr, 16'h0100); check("pin_79C_neg", 16'(pn), 16'd1);
    model(11'h400, 4, pr, po, pn); check("pin_400", pr, 16'h1024); check("pin_400_neg", 16'(pn), 16'd1);
    model(11'h7FF, 3, pr, po, pn); check("pin_7FF_d3", pr, 16'h0001); check("pin_7FF_d3_ovf", 16'(po), 16'd0);
`else
    model(11'h79C, 4, pr, po, pn); check("pin_79C", pr, 16'h1948);
    model(11'h7FF, 4, pr, po, pn); check("pin_7FF", pr, 16'h2047);
    model(11'h7FF, 3, pr, po, pn); check("pin_7FF_d3", pr, 16'h0047); check("pin_7FF_d3_ovf", 16'(po), 16'd1);
`endif

    // Basic conversion and latency.
    send(11'h020, 1'b0);
    wait_vld(lat);
    check("latency", 16'(lat), 16'(LAT));
    check("t1_bcd", bcd0, 16'h0032);
    check("t1_ovf", 16'(ovf0), 16'd0);
    @(negedge clk);

    // Back-to-back with bin_vld held high.
    send(11'h39C, 1'b1);
    send(11'h79C, 1'b1);
    send(11'h7FF, 1'b0);
    wait_vld(lat);
`ifdef BIN2BCD_SIGNED_EN
    check("t2_7FF", bcd0, 16'h0001);
    check("t2_7FF_d3", {4'h0, bcd1}, 16'h0001);
`else
    check("t2_7FF", bcd0, 16'h2047);
    check("t2_7FF_d3", {4'h0, bcd1}, 16'h0047);
    check("t2_7FF_d3_ovf", 16'(ovf1), 16'd1);
`endif
    @(negedge clk);

    send(11'h3E7, 1'b0);
    wait_vld(lat);
    check("t3_999", {4'h0, bcd1}, 16'h0999);
    check("t3_999_ovf", 16'(ovf1), 16'd0);
    @(negedge clk);

    // Backpressure: result held, new input ignored while DONE.
    bcd_rdy = 1'b0;
    send(11'h123, 1'b0);
    wait_vld(lat);
    cap = bcd0;
    bin = 11'h555; bin_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_bcd", bcd0, cap);
      check("bp_vld", 16'(vld0), 16'd1);
      check("bp_rdy", 16'(rdy0), 16'd0);
    end
    bcd_rdy = 1'b1;
    bin_vld = 1'b0;
    @(negedge clk);
    check("bp_consumed", 16'(vld0), 16'd0);

    // Reset in the middle of a conversion.
    send(11'h020, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rdy", 16'(rdy0), 16'd1);
    check("rst_vld", 16'(vld0), 16'd0);
    check("rst_bcd", bcd0, 16'h0000);
    send(11'h020, 1'b0);
    wait_vld(lat);
    check("rst_redo", bcd0, 16'h0032);
    @(negedge clk);

    // Randomized traffic with backpressure and occasional reset.
    repeat (3000) begin
      rst     = ($urandom_range(0, 199) == 0);
      bin_vld = ($urandom_range(0, 3) != 0);
      bin     = 11'($urandom);
      bcd_rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    rst = 1'b0; bin_vld = 1'b0; bcd_rdy = 1'b1;
    repeat (20) @(negedge clk);
    check("rand_activity", 16'(n_results >= 50), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
